cq_viola_sysid_check: RTL and testbench

Avalon-MM master that reads the two-word system-ID slave (address 0 = system ID, address 1 = build timestamp) after reset or on request. It compares both words against build-time expected values and reports pass/fail. It sits beside the system-ID slave on the same interconnect and gates "platform verified" status for boot logic and host-visible status registers. Each access has a timeout so a missing or hung slave yields a deterministic failure instead of a lock-up.

---
 rtl/cq_viola_sysid_check_pkg.sv | 7 +
 rtl/cq_viola_sysid_check_if.sv | 10 +
 rtl/cq_viola_sysid_check_tmo.sv | 19 +
 rtl/cq_viola_sysid_check.sv | 126 ++++++++++++
 tb/tb_cq_viola_sysid_check.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cq_viola_sysid_check_pkg.sv
// cq_viola_sysid_check_pkg: shared FSM encoding, slave word addresses and timeout counter width
package cq_viola_sysid_check_pkg;
   typedef enum logic [2:0] {IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FIN} state_e;
   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;
   localparam int TMO_W = 16;
endpackage

// File: rtl/cq_viola_sysid_check_if.sv
// cq_viola_sysid_check_if: Avalon-MM read-only bus between the checker and the system-ID slave
interface cq_viola_sysid_check_if;
   logic        address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;
   modport master(output address, read, input waitrequest, readdata, readdatavalid);
   modport slave(input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/cq_viola_sysid_check_tmo.sv
// cq_viola_sysid_check_tmo: per-access timeout counter, reloaded at each request, flags LIMIT-1 reached
module cq_viola_sysid_check_tmo
   import cq_viola_sysid_check_pkg::*;
#(
   parameter int LIMIT = 1024
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic expired
);
   logic [TMO_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? '0 : en ? cnt_q + TMO_W'(1) : cnt_q;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign expired = cnt_q == TMO_W'(LIMIT - 1);
endmodule

// File: rtl/cq_viola_sysid_check.sv
// cq_viola_sysid_check: reads system ID and build timestamp over Avalon-MM and reports whether both match
module cq_viola_sysid_check
   import cq_viola_sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECT_ID      = 32'hA0140807,
   parameter logic [31:0] EXPECT_TS      = 32'h53E612CC,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   cq_viola_sysid_check_if.master avm,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  id_ok,
   output logic                  ts_ok,
   output logic                  timeout,
   output logic [31:0]           id_value,
   output logic [31:0]           ts_value
);
   state_e      state_q, state_d;
   logic        auto_q, auto_d, read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
   logic        pass_q, pass_d, id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, tmo_q, tmo_d;
   logic [31:0] id_q, id_d, ts_q, ts_d;
   logic        load, en, expired;
   cq_viola_sysid_check_tmo #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clock(clock), .reset_n(reset_n), .load(load), .en(en), .expired(expired)
   );
   always_comb begin
      state_d = state_q;
      auto_d  = auto_q;
      pass_d  = pass_q;
      id_ok_d = id_ok_q;
      ts_ok_d = ts_ok_q;
      tmo_d   = tmo_q;
      id_d    = id_q;
      ts_d    = ts_q;
      case (state_q)
         IDLE: if (start || auto_q) begin
            state_d = REQ_ID;
            auto_d  = 1'b0;
            pass_d  = 1'b0;
            id_ok_d = 1'b0;
            ts_ok_d = 1'b0;
            tmo_d   = 1'b0;
            id_d    = '0;
            ts_d    = '0;
         end
         REQ_ID, REQ_TS: begin
            if (expired) begin
               state_d = FIN;
               tmo_d   = 1'b1;
            end else if (!avm.waitrequest) state_d = (state_q == REQ_ID) ? WAIT_ID : WAIT_TS;
         end
         // data arriving on the expiry cycle still counts
         WAIT_ID: begin
            if (avm.readdatavalid) begin
               id_d    = avm.readdata;
               id_ok_d = avm.readdata == EXPECT_ID;
               state_d = REQ_TS;
            end else if (expired) begin
               state_d = FIN;
               tmo_d   = 1'b1;
            end
         end
         WAIT_TS: begin
            if (avm.readdatavalid) begin
               ts_d    = avm.readdata;
               ts_ok_d = avm.readdata == EXPECT_TS;
               state_d = FIN;
            end else if (expired) begin
               state_d = FIN;
               tmo_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      done_d = state_d == FIN;
      if (done_d) pass_d = id_ok_d && ts_ok_d;
      busy_d = state_d != IDLE && state_d != FIN;
      read_d = state_d == REQ_ID || state_d == REQ_TS;
      addr_d = (state_d == REQ_TS) ? ADDR_TS : ADDR_ID;
      load   = read_d && state_d != state_q;
      en     = state_q != IDLE && state_q != FIN;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         auto_q  <= AUTO_START;
         read_q  <= 1'b0;
         addr_q  <= ADDR_ID;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         id_ok_q <= 1'b0;
         ts_ok_q <= 1'b0;
         tmo_q   <= 1'b0;
         id_q    <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         auto_q  <= auto_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         id_ok_q <= id_ok_d;
         ts_ok_q <= ts_ok_d;
         tmo_q   <= tmo_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
      end
   assign avm.read    = read_q;
   assign avm.address = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = tmo_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;
endmodule

// File: tb/tb_cq_viola_sysid_check.sv
// tb_cq_viola_sysid_check: directed checks of the sysid checker against a cycle-level outcome model
module tb_cq_viola_sysid_check;
   localparam logic [31:0] EXP_ID = 32'hA0140807;
   localparam logic [31:0] EXP_TS = 32'h53E612CC;
   localparam int TMO = 8;
   typedef struct {int ws; int lat; bit nodata; logic [31:0] id_w; logic [31:0] ts_w;} cfg_t;
   typedef struct {int done_cyc; logic [31:0] id_v; logic [31:0] ts_v; logic id_ok; logic ts_ok; logic tmo; logic pass;} exp_t;
   logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;
   cq_viola_sysid_check_if avm();
   cq_viola_sysid_check #(
      .EXPECT_ID(EXP_ID), .EXPECT_TS(EXP_TS), .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .avm(avm),
      .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
      .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
   );
   always #5 clock = ~clock;
   int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0, exp_start = 0;
   bit exp_valid = 1'b0;
   cfg_t cfg;
   exp_t m;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask
   // Each access: counter starts at 0 on the request cycle; data lands ws+lat cycles later and
   // wins if that is no later than TMO-1, otherwise the check ends TMO cycles after the request.
   function automatic exp_t predict(cfg_t c, int c0);
      exp_t e;
      int t = c0 + 1;
      logic [31:0] w;
      e = '{done_cyc: 0, id_v: '0, ts_v: '0, id_ok: 1'b0, ts_ok: 1'b0, tmo: 1'b0, pass: 1'b0};
      for (int k = 0; k < 2; k++)
         if (!e.tmo) begin
            if (!c.nodata && c.ws + c.lat <= TMO - 1) begin
               w = (k == 0) ? c.id_w : c.ts_w;
               if (k == 0) begin e.id_v = w; e.id_ok = (w == EXP_ID); end
               else begin e.ts_v = w; e.ts_ok = (w == EXP_TS); end
               t += c.ws + c.lat + 1;
            end else begin
               e.tmo = 1'b1;
               t += TMO;
            end
         end
      e.done_cyc = t;
      e.pass = e.id_ok && e.ts_ok;
      return e;
   endfunction
   int held = 0, pend = 0;
   logic paddr = 1'b0;
   always @(negedge clock) begin
      if (!reset_n) begin
         held = 0; pend = 0;
         avm.waitrequest = 1'b0; avm.readdatavalid = 1'b0; avm.readdata = '0;
      end else begin
         avm.readdatavalid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && !cfg.nodata) begin
               avm.readdatavalid = 1'b1;
               avm.readdata = paddr ? cfg.ts_w : cfg.id_w;
            end
         end
         if (avm.read) begin
            avm.waitrequest = held < cfg.ws;
            held++;
            if (!avm.waitrequest) begin pend = cfg.lat; paddr = avm.address; held = 0; end
         end else begin
            held = 0; avm.waitrequest = 1'b0;
         end
      end
   end
   logic stall_q = 1'b0, addr_q = 1'b0;
   always @(posedge clock) begin
      stall_q <= reset_n && avm.read && avm.waitrequest;
      addr_q  <= avm.address;
   end
   always @(negedge clock)
      if (reset_n) begin
         if (done) n_done++;
         if (stall_q) begin
            chk("stall_read", avm.read, 1);
            chk("stall_addr", avm.address, addr_q);
         end
         if (exp_valid) begin
            chk("done", done, cyc == m.done_cyc);
            chk("busy", busy, cyc > exp_start && cyc < m.done_cyc);
            if (cyc >= m.done_cyc) begin
               chk("pass", pass, m.pass);
               chk("id_ok", id_ok, m.id_ok);
               chk("ts_ok", ts_ok, m.ts_ok);
               chk("timeout", timeout, m.tmo);
               chk("id_value", id_value, m.id_v);
               chk("ts_value", ts_value, m.ts_v);
               chk("idle_read", avm.read, 0);
            end
         end
      end
   task automatic wait_cyc(int t);
      while (cyc < t) @(negedge clock);
   endtask
   task automatic launch(cfg_t c, bit by_reset);
      cfg = c;
      exp_start = cyc;
      m = predict(c, cyc);
      exp_valid = 1'b1;
      if (by_reset) reset_n = 1'b1;
      else start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask
   task automatic finish_run(int lit_done);
      wait_cyc(exp_start + lit_done);
      chk("lit_done", done, 1);
      wait_cyc(m.done_cyc + 3);
   endtask
   cfg_t ok_c;
   int c0, d0;
   initial begin
      ok_c = '{ws: 0, lat: 1, nodata: 1'b0, id_w: EXP_ID, ts_w: EXP_TS};
      cfg = ok_c;
      repeat (3) @(negedge clock);
      chk("rst_read", avm.read, 0);
      chk("rst_addr", avm.address, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_ok", {id_ok, ts_ok, timeout}, 0);
      chk("rst_vals", id_value | ts_value, 0);
      launch(ok_c, 1'b1);
      finish_run(5);
      chk("t1_pass", {pass, id_ok, ts_ok, timeout}, 4'b1110);
      launch('{ws: 0, lat: 1, nodata: 1'b0, id_w: 32'h0, ts_w: EXP_TS}, 1'b0);
      finish_run(5);
      chk("t2_flags", {pass, id_ok, ts_ok}, 3'b001);
      chk("t2_id", id_value, 32'h0);
      chk("t2_ts", ts_value, 32'h53E612CC);
      launch('{ws: 2, lat: 2, nodata: 1'b0, id_w: EXP_ID, ts_w: EXP_TS}, 1'b0);
      finish_run(11);
      chk("t3_pass", pass, 1);
      launch('{ws: 0, lat: 1, nodata: 1'b1, id_w: EXP_ID, ts_w: EXP_TS}, 1'b0);
      finish_run(9);
      chk("t4_flags", {timeout, pass, id_ok, ts_ok, avm.read}, 5'b10000);
      chk("t4_id", id_value, 32'h0);
      launch('{ws: 0, lat: 7, nodata: 1'b0, id_w: EXP_ID, ts_w: EXP_TS}, 1'b0);
      finish_run(17);
      chk("t5_edge", {pass, timeout}, 2'b10);
      launch('{ws: 0, lat: 8, nodata: 1'b0, id_w: EXP_ID, ts_w: EXP_TS}, 1'b0);
      finish_run(9);
      chk("t6_edge", {pass, timeout, id_ok}, 3'b010);
      chk("t6_id", id_value, 32'h0);
      d0 = n_done;
      c0 = cyc;
      launch(ok_c, 1'b0);
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      finish_run(5);
      wait_cyc(c0 + 25);
      chk("t7_one_done", n_done - d0, 1);
      c0 = cyc;
      launch('{ws: 0, lat: 3, nodata: 1'b0, id_w: EXP_ID, ts_w: EXP_TS}, 1'b0);
      wait_cyc(c0 + 6);
      chk("t8_pre_id", id_value, 32'hA0140807);
      chk("t8_pre_busy", busy, 1);
      exp_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("t8_rst_bus", {avm.read, avm.address, busy, done}, 0);
      chk("t8_rst_flags", {pass, id_ok, ts_ok, timeout}, 0);
      chk("t8_rst_vals", id_value | ts_value, 0);
      @(negedge clock);
      @(negedge clock);
      launch(ok_c, 1'b1);
      finish_run(5);
      chk("t8_pass", {pass, id_ok, ts_ok, timeout}, 4'b1110);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
